// File: rtl/axis_engine_scheduler.sv
// axis_engine_scheduler: round-robin, packet-granular sharing of one store-and-forward AXI-Stream engine between two requesters
module axis_engine_scheduler #(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_LEN    = 768,
    parameter int CNT_W      = 10
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [DATA_WIDTH-1:0] s0_axis_tdata,
    input  logic                  s0_axis_tvalid,
    output logic                  s0_axis_tready,
    input  logic                  s0_axis_tlast,
    input  logic [DATA_WIDTH-1:0] s1_axis_tdata,
    input  logic                  s1_axis_tvalid,
    output logic                  s1_axis_tready,
    input  logic                  s1_axis_tlast,
    output logic [DATA_WIDTH-1:0] eng_m_axis_tdata,
    output logic                  eng_m_axis_tvalid,
    input  logic                  eng_m_axis_tready,
    output logic                  eng_m_axis_tlast,
    input  logic [DATA_WIDTH-1:0] eng_s_axis_tdata,
    input  logic                  eng_s_axis_tvalid,
    output logic                  eng_s_axis_tready,
    input  logic                  eng_s_axis_tlast,
    output logic [DATA_WIDTH-1:0] m0_axis_tdata,
    output logic                  m0_axis_tvalid,
    input  logic                  m0_axis_tready,
    output logic                  m0_axis_tlast,
    output logic [DATA_WIDTH-1:0] m1_axis_tdata,
    output logic                  m1_axis_tvalid,
    input  logic                  m1_axis_tready,
    output logic                  m1_axis_tlast,
    output logic                  busy,
    output logic                  grant_id,
    output logic                  err_trunc,
    output logic                  pkt_done
);
    typedef enum logic [1:0] {IDLE, FWD, FLUSH, DRAIN} state_t;

    state_t           state, state_nx;
    logic             grant_nx;
    logic             last_grant;
    logic             trunc;
    logic [CNT_W-1:0] beat_cnt;
    logic [DATA_WIDTH-1:0] sg_tdata;
    logic             sg_tvalid, sg_tlast, sg_tready;
    logic             mg_tvalid, mg_tready;
    logic             at_max;

    assign sg_tdata  = grant_id ? s1_axis_tdata  : s0_axis_tdata;
    assign sg_tvalid = grant_id ? s1_axis_tvalid : s0_axis_tvalid;
    assign sg_tlast  = grant_id ? s1_axis_tlast  : s0_axis_tlast;
    assign mg_tready = grant_id ? m1_axis_tready : m0_axis_tready;
    assign at_max    = beat_cnt == CNT_W'(MAX_LEN - 1);

    assign s0_axis_tready   = sg_tready && !grant_id;
    assign s1_axis_tready   = sg_tready &&  grant_id;
    assign m0_axis_tvalid   = mg_tvalid && !grant_id;
    assign m1_axis_tvalid   = mg_tvalid &&  grant_id;
    assign m0_axis_tdata    = eng_s_axis_tdata;
    assign m1_axis_tdata    = eng_s_axis_tdata;
    assign m0_axis_tlast    = eng_s_axis_tlast;
    assign m1_axis_tlast    = eng_s_axis_tlast;
    assign eng_m_axis_tdata = sg_tdata;
    assign busy             = state != IDLE;

    // Next state, arbitration and the combinational stream steering for the current state
    always_comb begin
        state_nx          = state;
        grant_nx          = grant_id;
        sg_tready         = 1'b0;
        mg_tvalid         = 1'b0;
        eng_m_axis_tvalid = 1'b0;
        eng_m_axis_tlast  = 1'b0;
        eng_s_axis_tready = 1'b0;
        err_trunc         = 1'b0;
        pkt_done          = 1'b0;
        case (state)
            IDLE: begin
                if (s0_axis_tvalid || s1_axis_tvalid) begin
                    grant_nx = (s0_axis_tvalid && s1_axis_tvalid) ? !last_grant : s1_axis_tvalid;
                    state_nx = FWD;
                end
            end
            FWD: begin
                eng_m_axis_tvalid = sg_tvalid;
                eng_m_axis_tlast  = sg_tlast || at_max;
                sg_tready         = eng_m_axis_tready;
                if (sg_tvalid && eng_m_axis_tready && eng_m_axis_tlast) begin
                    state_nx  = sg_tlast ? DRAIN : FLUSH;
                    err_trunc = !sg_tlast && !trunc;
                end
            end
            FLUSH: begin
                sg_tready = 1'b1;
                if (sg_tvalid && sg_tlast)
                    state_nx = DRAIN;
            end
            default: begin
                mg_tvalid         = eng_s_axis_tvalid;
                eng_s_axis_tready = mg_tready;
                if (eng_s_axis_tvalid && mg_tready && eng_s_axis_tlast) begin
                    pkt_done = 1'b1;
                    state_nx = IDLE;
                end
            end
        endcase
    end

    // State, grant bookkeeping and beat counting; beat_cnt restarts at zero for every grant
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state      <= IDLE;
            grant_id   <= 1'b0;
            last_grant <= 1'b1;
            beat_cnt   <= '0;
            trunc      <= 1'b0;
        end else begin
            state    <= state_nx;
            grant_id <= grant_nx;
            if (state == IDLE)
                beat_cnt <= '0;
            else if (state == FWD && eng_m_axis_tvalid && eng_m_axis_tready)
                beat_cnt <= beat_cnt + 1'b1;
            if (err_trunc)
                trunc <= 1'b1;
            else if (pkt_done)
                trunc <= 1'b0;
            if (pkt_done)
                last_grant <= grant_id;
        end
    end
endmodule

// File: tb/tb_axis_engine_scheduler.sv
// tb_axis_engine_scheduler: directed bench with an echoing store-and-forward engine model and per-requester scoreboards
module tb_axis_engine_scheduler;
    localparam int ML = 768;

    logic       aclk = 1'b0;
    logic       aresetn = 1'b0;
    logic [7:0] s0_tdata = '0, s1_tdata = '0;
    logic       s0_tvalid = 1'b0, s0_tlast = 1'b0, s0_tready;
    logic       s1_tvalid = 1'b0, s1_tlast = 1'b0, s1_tready;
    logic [7:0] eng_m_tdata;
    logic       eng_m_tvalid, eng_m_tlast;
    logic       eng_m_tready = 1'b1;
    logic [7:0] eng_s_tdata = '0;
    logic       eng_s_tvalid = 1'b0, eng_s_tlast = 1'b0, eng_s_tready;
    logic [7:0] m0_tdata, m1_tdata;
    logic       m0_tvalid, m0_tlast, m1_tvalid, m1_tlast;
    logic       m0_tready = 1'b1, m1_tready = 1'b1;
    logic       busy, grant_id, err_trunc, pkt_done;

    logic [8:0] src0[$], src1[$];
    logic [9:0] exp0[$], exp1[$];
    logic [8:0] eng_cur[$], eng_out[$];
    logic       glog[$];
    int         eng_last_len = 0;
    bit         rnd = 1'b0;
    int         m0_beats = 0, m1_beats = 0, err_cnt = 0, done_cnt = 0, drop_cnt = 0;
    int         checks = 0, failures = 0;
    int         s_m0, s_m1, s_err, s_done, s_drop;
    logic       busy_q = 1'b0;
    logic       h0, h1, ehi, eho;
    logic [8:0] edi;
    logic [9:0] e0, e1;

    axis_engine_scheduler #(.DATA_WIDTH(8), .MAX_LEN(ML), .CNT_W(10)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s0_axis_tdata(s0_tdata), .s0_axis_tvalid(s0_tvalid), .s0_axis_tready(s0_tready), .s0_axis_tlast(s0_tlast),
        .s1_axis_tdata(s1_tdata), .s1_axis_tvalid(s1_tvalid), .s1_axis_tready(s1_tready), .s1_axis_tlast(s1_tlast),
        .eng_m_axis_tdata(eng_m_tdata), .eng_m_axis_tvalid(eng_m_tvalid), .eng_m_axis_tready(eng_m_tready), .eng_m_axis_tlast(eng_m_tlast),
        .eng_s_axis_tdata(eng_s_tdata), .eng_s_axis_tvalid(eng_s_tvalid), .eng_s_axis_tready(eng_s_tready), .eng_s_axis_tlast(eng_s_tlast),
        .m0_axis_tdata(m0_tdata), .m0_axis_tvalid(m0_tvalid), .m0_axis_tready(m0_tready), .m0_axis_tlast(m0_tlast),
        .m1_axis_tdata(m1_tdata), .m1_axis_tvalid(m1_tvalid), .m1_axis_tready(m1_tready), .m1_axis_tlast(m1_tlast),
        .busy(busy), .grant_id(grant_id), .err_trunc(err_trunc), .pkt_done(pkt_done)
    );

    always #5 aclk = ~aclk;

    // Requester 0 source: presents the head of src0, pops it after a handshake
    always begin
        @(negedge aclk);
        h0 = s0_tvalid && s0_tready;
        @(posedge aclk);
        #1;
        if (h0 && src0.size() > 0) void'(src0.pop_front());
        s0_tvalid = src0.size() > 0;
        {s0_tlast, s0_tdata} = s0_tvalid ? src0[0] : 9'h0;
    end

    // Requester 1 source
    always begin
        @(negedge aclk);
        h1 = s1_tvalid && s1_tready;
        @(posedge aclk);
        #1;
        if (h1 && src1.size() > 0) void'(src1.pop_front());
        s1_tvalid = src1.size() > 0;
        {s1_tlast, s1_tdata} = s1_tvalid ? src1[0] : 9'h0;
    end

    // Engine model: stores a whole packet, then echoes it unchanged; cleared by aresetn
    always begin
        @(negedge aclk);
        ehi = eng_m_tvalid && eng_m_tready;
        eho = eng_s_tvalid && eng_s_tready;
        edi = {eng_m_tlast, eng_m_tdata};
        @(posedge aclk);
        #1;
        if (!aresetn) begin
            eng_cur.delete();
            eng_out.delete();
        end else begin
            if (eho && eng_out.size() > 0) void'(eng_out.pop_front());
            if (ehi) begin
                eng_cur.push_back(edi);
                if (edi[8]) begin
                    eng_last_len = eng_cur.size();
                    foreach (eng_cur[i]) eng_out.push_back(eng_cur[i]);
                    eng_cur.delete();
                end
            end
        end
        eng_s_tvalid = eng_out.size() > 0;
        {eng_s_tlast, eng_s_tdata} = eng_s_tvalid ? eng_out[0] : 9'h0;
        eng_m_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Output monitor: pops the scoreboard on every result beat and tallies events
    always @(negedge aclk) begin
        if (aresetn) begin
            if (m0_tvalid && m0_tready) begin
                e0 = 10'h3ff;
                if (exp0.size() > 0) e0 = exp0.pop_front();
                checks++;
                assert ({1'b0, m0_tlast, m0_tdata} === e0) else begin
                    failures++;
                    $error("FAIL m0_beat observed=%h expected=%h", {1'b0, m0_tlast, m0_tdata}, e0);
                end
                m0_beats++;
            end
            if (m1_tvalid && m1_tready) begin
                e1 = 10'h3ff;
                if (exp1.size() > 0) e1 = exp1.pop_front();
                checks++;
                assert ({1'b0, m1_tlast, m1_tdata} === e1) else begin
                    failures++;
                    $error("FAIL m1_beat observed=%h expected=%h", {1'b0, m1_tlast, m1_tdata}, e1);
                end
                m1_beats++;
            end
            if (err_trunc) err_cnt++;
            if (pkt_done) done_cnt++;
            if (((s0_tvalid && s0_tready) || (s1_tvalid && s1_tready)) && !eng_m_tvalid) drop_cnt++;
            if (busy && !busy_q) glog.push_back(grant_id);
        end
        busy_q = busy;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push_pkt(input bit id, input int n, input logic [7:0] base);
        int k;
        logic [8:0] b;
        logic [9:0] e;
        k = n > ML ? ML : n;
        for (int i = 0; i < n; i++) begin
            b = {i == n - 1, 8'(base + i)};
            if (id) src1.push_back(b); else src0.push_back(b);
        end
        for (int i = 0; i < k; i++) begin
            e = {1'b0, i == k - 1, 8'(base + i)};
            if (id) exp1.push_back(e); else exp0.push_back(e);
        end
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge aclk);
            n++;
        end while (!(src0.size() == 0 && src1.size() == 0 && exp0.size() == 0 && exp1.size() == 0 && !busy) && n < 6000);
        chk({tag, "_complete"}, 32'(n < 6000), 1);
    endtask

    task automatic snap();
        s_m0 = m0_beats;
        s_m1 = m1_beats;
        s_err = err_cnt;
        s_done = done_cnt;
        s_drop = drop_cnt;
    endtask

    initial begin
        int n;
        logic [3:0] go;
        push_pkt(0, 2, 8'h20);
        push_pkt(1, 2, 8'h30);
        repeat (3) @(negedge aclk);
        chk("reset_outputs", 32'({busy, err_trunc, pkt_done, s0_tready, s1_tready, eng_m_tvalid, eng_s_tready, m0_tvalid, m1_tvalid}), 0);
        chk("reset_grant_id", 32'(grant_id), 0);
        aresetn = 1'b1;
        wait_idle("tie1");
        push_pkt(0, 1, 8'h50);
        push_pkt(1, 1, 8'h60);
        wait_idle("tie2_single_beat");
        chk("grant_log_len", glog.size(), 4);
        go = {glog[0], glog[1], glog[2], glog[3]};
        chk("grant_order", 32'(go), 32'b0101);

        snap();
        push_pkt(0, 4, 8'h10);
        wait_idle("single");
        chk("single_m0_beats", m0_beats - s_m0, 4);
        chk("single_m1_beats", m1_beats - s_m1, 0);
        chk("single_pkt_done", done_cnt - s_done, 1);

        snap();
        push_pkt(1, 770, 8'h00);
        wait_idle("trunc");
        chk("trunc_err_pulses", err_cnt - s_err, 1);
        chk("trunc_dropped", drop_cnt - s_drop, 2);
        chk("trunc_engine_len", eng_last_len, ML);
        chk("trunc_m1_beats", m1_beats - s_m1, ML);
        chk("trunc_m0_beats", m0_beats - s_m0, 0);

        snap();
        rnd = 1'b1;
        push_pkt(0, 20, 8'h80);
        n = 0;
        do begin
            @(negedge aclk);
            n++;
        end while (m0_beats == s_m0 && n < 2000);
        chk("bp_drain_started", 32'(n < 2000), 1);
        @(posedge aclk);
        #1 m0_tready = 1'b0;
        repeat (5) begin
            @(negedge aclk);
            chk("bp_eng_s_held", 32'(eng_s_tready), 0);
        end
        @(posedge aclk);
        #1 m0_tready = 1'b1;
        wait_idle("backpressure");
        rnd = 1'b0;
        chk("bp_m0_beats", m0_beats - s_m0, 20);
        chk("bp_pkt_done", done_cnt - s_done, 1);

        push_pkt(0, 8, 8'hA0);
        n = 0;
        do begin
            @(negedge aclk);
            n++;
        end while (eng_cur.size() != 3 && n < 200);
        chk("rst_mid_reached_fwd", 32'(n < 200), 1);
        aresetn = 1'b0;
        src0.delete();
        exp0.delete();
        @(negedge aclk);
        chk("rst_mid_outputs", 32'({busy, s0_tready, s1_tready, eng_m_tvalid, eng_s_tready, m0_tvalid, m1_tvalid}), 0);
        @(negedge aclk);
        aresetn = 1'b1;

        snap();
        push_pkt(0, ML, 8'h05);
        wait_idle("exact_len");
        chk("exact_err_pulses", err_cnt - s_err, 0);
        chk("exact_dropped", drop_cnt - s_drop, 0);
        chk("exact_engine_len", eng_last_len, ML);
        chk("exact_m0_beats", m0_beats - s_m0, ML);
        chk("exact_pkt_done", done_cnt - s_done, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/axis_engine_scheduler.md
# axis_engine_scheduler

Packet-granular scheduler that shares one store-and-forward AXI-Stream engine (the 768-beat buffer/delay stage of the JPEG encoder datapath) between two upstream requesters. It grants one whole input packet at a time by round-robin, enforces the engine's maximum packet length, and routes the engine's result packet back to the requester that supplied it. A new packet is never granted until the previous result packet has fully drained.

## Interface
- DATA_WIDTH, 8, tdata width of every stream
- MAX_LEN, 768, maximum beats per packet accepted by the engine (2..1023)
- CNT_W, 10, beat-counter width; must satisfy 2^CNT_W > MAX_LEN
- aclk  in  1  single clock; all logic on rising edge
- aresetn  in  1  reset; synchronous, active-low
- s0_axis_tdata/tvalid/tready/tlast  in/in/out/in  DATA_WIDTH/1/1/1  requester 0 input stream
- s1_axis_tdata/tvalid/tready/tlast  in/in/out/in  DATA_WIDTH/1/1/1  requester 1 input stream
- eng_m_axis_tdata/tvalid/tready/tlast  out/out/in/out  DATA_WIDTH/1/1/1  stream into the engine
- eng_s_axis_tdata/tvalid/tready/tlast  in/in/out/in  DATA_WIDTH/1/1/1  result stream from the engine
- m0_axis_tdata/tvalid/tready/tlast  out/out/in/out  DATA_WIDTH/1/1/1  result stream to requester 0
- m1_axis_tdata/tvalid/tready/tlast  out/out/in/out  DATA_WIDTH/1/1/1  result stream to requester 1
- busy  out  1  high whenever state is not IDLE
- grant_id  out  1  registered id of the current/last granted requester
- err_trunc  out  1  one-cycle pulse when a packet is truncated at MAX_LEN
- pkt_done  out  1  one-cycle pulse on the final result beat handshake

## Operation
- Registered state: state {IDLE, FWD, FLUSH, DRAIN}, grant_id, last_grant, beat_cnt[CNT_W-1:0], trunc.
- IDLE: all s*_tready = 0, eng_m_tvalid = 0, eng_s_tready = 0. If only one s*_tvalid is high, grant it. If both are high, grant the requester != last_grant. Next state FWD, beat_cnt <= 0. With no valid input, stay in IDLE.
- FWD, combinational pass-through from the granted requester g:
  - eng_m_tdata = sg_tdata; eng_m_tvalid = sg_tvalid; sg_tready = eng_m_tready.
  - eng_m_tlast = sg_tlast OR (beat_cnt == MAX_LEN-1).
  - The non-granted s*_tready is 0.
- FWD handshake handling:
  - Each eng_m handshake increments beat_cnt.
  - A handshake with eng_m_tlast and sg_tlast = 1 goes to DRAIN.
  - A handshake with forced tlast (sg_tlast = 0) sets trunc, pulses err_trunc and goes to FLUSH.
- FLUSH: sg_tready = 1 and the beats are discarded (eng_m_tvalid = 0). The handshake with sg_tlast goes to DRAIN.
- DRAIN:
  - mg_tdata/tvalid/tlast = eng_s_*; eng_s_tready = mg_tready.
  - The non-granted m*_tvalid is 0.
  - The handshake with eng_s_tlast pulses pkt_done, sets last_grant <= grant_id, clears trunc, and goes to IDLE.
- Outside DRAIN, eng_s_tready = 0. Engine output is held off in that case, never dropped.
- m*_tdata = eng_s_tdata at all times. Only tvalid is gated.

## Timing
- Reset values: state IDLE, grant_id 0, last_grant 1 (requester 0 wins the first tie), beat_cnt 0, trunc 0. At reset, all tvalid/tready outputs, busy, err_trunc and pkt_done are 0.
- Arbitration costs 1 cycle: input valid in IDLE at cycle N gives the first possible transfer at cycle N+1. The data path has zero added latency (combinational).
- Turnaround: the final result handshake at cycle N puts the FSM in IDLE at N+1. The earliest next grant is effective at N+2.
- Requester tvalid may rise, or a second requester may become valid, during FWD/FLUSH/DRAIN. This does not change the grant. Grant changes happen only in IDLE.
- A single-beat packet (tlast on beat 0) goes FWD to DRAIN after one handshake.
- A packet of exactly MAX_LEN beats with tlast on the final beat is not truncated: no err_trunc, no FLUSH.
- Backpressure in any state stalls without loss. tdata/tlast presented to the engine and outputs follow the source; no state advances without a handshake.
- Reset asserted mid-packet forces IDLE on the next edge. The partial engine packet is abandoned, and the engine is reset by the same aresetn.

## Test plan
- Single requester: s0 sends 4 beats 0x10..0x13, and the engine echoes them → m0 receives 0x10..0x13 with tlast on 0x13, m1_tvalid stays 0, one pkt_done pulse.
- Tie: s0 and s1 both valid in the first cycle after reset → s0 is granted first and s1 second. Both valid again → s0 third (alternation).
- Truncation with MAX_LEN = 768: s1 sends 770 beats → engine sees 768 beats with tlast on beat 767, one err_trunc pulse, beats 768–769 consumed and dropped, the result routed to m1.
- Exact length: a 768-beat packet with source tlast on beat 767 → no err_trunc, no FLUSH cycles.
- Backpressure: random eng_m_tready and m0_tready held low for 5 cycles mid-drain → result data is identical to the input, and no beat is lost or duplicated.
- Reset in FWD after 3 beats → the next cycle has busy = 0 and all tready/tvalid = 0, and the next packet starts with beat_cnt = 0.
